// File: rtl/five_to_twenty.sv
// five_to_twenty: width-expanding gearbox, 5-word input beats -> 20-word
// output beats. Four accepted input beats are packed into one output beat,
// earliest word in the lowest bits (little-endian word order).
//
// Handshake: a beat moves on a rising edge where valid & ready are both high
// on that side. A producer holds its data/valid stable until it is taken;
// ready may depend combinationally on the far side's ready, never on the
// same side's valid.
//
// Ports:
//   clk         single clock, rising edge
//   arst        synchronous active-high reset (priority over everything)
//   din         input beat, word 0 in bits [WORD_LEN-1:0]
//   din_valid   din holds a beat
//   din_ready   block can accept a beat this cycle
//   dout        output beat, word 0 in the LSBs
//   dout_valid  dout holds a beat
//   dout_ready  downstream accepts dout this cycle
module five_to_twenty #(
  parameter int WORD_LEN = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [5*WORD_LEN-1:0]   din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [20*WORD_LEN-1:0]  dout,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  localparam int BW = 5 * WORD_LEN;

  // cnt = number of beats of the current group already held in acc (0..3).
  logic [1:0]      cnt;
  logic [3*BW-1:0] acc;

  logic accept;
  logic consume;
  logic complete;

  // Only the group-completing beat needs room in the output register, so
  // backpressure stalls input only when cnt==3 and dout is still occupied.
  assign din_ready = (cnt != 2'd3) | ~dout_valid | dout_ready;
  assign accept    = din_valid & din_ready;
  assign consume   = dout_valid & dout_ready;
  assign complete  = accept & (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt        <= 2'd0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (accept) begin
        case (cnt)
          2'd0:    acc[BW-1:0]      <= din;
          2'd1:    acc[2*BW-1:BW]   <= din;
          2'd2:    acc[3*BW-1:2*BW] <= din;
          default: ;  // 4th beat goes straight to dout below
        endcase
        // 3 -> 0 wrap closes the group.
        cnt <= cnt + 2'd1;
      end

      // Completion wins over consume so a back-to-back group has no bubble.
      if (complete) begin
        dout       <= {din, acc};
        dout_valid <= 1'b1;
      end else if (consume) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_five_to_twenty.sv
module tb_five_to_twenty;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            arst;
  logic [5*W-1:0]  din;
  logic            din_valid;
  logic            din_ready;
  logic [20*W-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;

  five_to_twenty #(.WORD_LEN(W)) dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [20*W-1:0] act, input logic [20*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [5*W-1:0] mk5(input int base);
    logic [5*W-1:0] r;
    for (int j = 0; j < 5; j++) r[j*W +: W] = W'(base + j);
    return r;
  endfunction

  function automatic logic [20*W-1:0] mk20(input int base);
    logic [20*W-1:0] r;
    for (int j = 0; j < 20; j++) r[j*W +: W] = W'(base + j);
    return r;
  endfunction

  // ---------------- scoreboard / model ----------------
  // Model: a word stream grouped by fours into an output queue of depth 1.
  // Inputs change only at posedge+1, so the values seen at a negedge are the
  // ones the next rising edge samples; the model predicts that edge.
  logic [20*W-1:0] exp_q[$];
  logic [20*W-1:0] part;
  int              m_cnt = 0;
  int              out_cnt = 0;
  bit              model_on = 0;

  always @(negedge clk) begin
    bit m_ready;
    bit m_acc;
    m_ready = (m_cnt != 3) || (exp_q.size() == 0) || (dout_ready === 1'b1);
    if (model_on) begin
      chk("sb dout_valid", {319'd0, dout_valid}, {319'd0, exp_q.size() != 0});
      chk("sb din_ready", {319'd0, din_ready}, {319'd0, m_ready});
      if (exp_q.size() != 0) chk("sb dout", dout, exp_q[0]);
    end
    if (arst) begin
      exp_q.delete();
      m_cnt    = 0;
      part     = '0;
      model_on = 1;
    end else if (model_on) begin
      m_acc = din_valid && m_ready;
      if (exp_q.size() != 0 && dout_ready) begin
        void'(exp_q.pop_front());
        out_cnt++;
      end
      if (m_acc) begin
        part = {din, part[20*W-1:5*W]};
        m_cnt++;
        if (m_cnt == 4) begin
          exp_q.push_back(part);
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5*W-1:0] d);
    bit got;
    int n;
    got = 0;
    n = 0;
    din = d;
    din_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = din_ready;
      step();
      n++;
    end
    din_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send timeout: din_ready low for %0d cycles, required acceptance", n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int o0;
    int nxt;
    bit r;
    arst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset dout_valid", {319'd0, dout_valid}, 320'd0);
    chk("reset dout", dout, 320'd0);
    chk("reset din_ready", {319'd0, din_ready}, 320'd1);
    step();
    arst = 1'b0;

    // Basic pack: words 1..20
    dout_ready = 1'b1;
    send(mk5(1)); send(mk5(6)); send(mk5(11)); send(mk5(16));
    @(negedge clk);
    chk("basic dout_valid", {319'd0, dout_valid}, 320'd1);
    chk("basic dout", dout, mk20(1));
    chk("basic word0", {304'd0, dout[15:0]}, 320'd1);
    chk("basic word19", {304'd0, dout[319:304]}, 320'd20);
    step();
    @(negedge clk);
    chk("basic pulse end", {319'd0, dout_valid}, 320'd0);
    step();

    // Backpressure
    dout_ready = 1'b0;
    send(mk5(1)); send(mk5(6)); send(mk5(11)); send(mk5(16));
    send(mk5(21)); send(mk5(26)); send(mk5(31));
    din = mk5(36);
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp din_ready low", {319'd0, din_ready}, 320'd0);
      chk("bp dout held", dout, mk20(1));
      step();
    end
    dout_ready = 1'b1;
    @(negedge clk);
    chk("bp din_ready release", {319'd0, din_ready}, 320'd1);
    step();
    din_valid = 1'b0;
    @(negedge clk);
    chk("bp next valid", {319'd0, dout_valid}, 320'd1);
    chk("bp next dout", dout, mk20(21));
    step();

    // Streaming: 40 beats, 10 outputs, din_ready always high
    o0 = out_cnt;
    din_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = mk5(41 + 5 * i);
      @(negedge clk);
      chk("stream din_ready", {319'd0, din_ready}, 320'd1);
      step();
    end
    din_valid = 1'b0;
    step();
    chk("stream outputs", 320'(out_cnt - o0), 320'd10);

    // Reset mid-group
    send(mk5(1)); send(mk5(6));
    arst = 1'b1;
    step();
    arst = 1'b0;
    send(mk5(101)); send(mk5(106)); send(mk5(111)); send(mk5(116));
    @(negedge clk);
    chk("midrst valid", {319'd0, dout_valid}, 320'd1);
    chk("midrst dout", dout, mk20(101));
    step();

    // Zero data
    for (int i = 0; i < 4; i++) send('0);
    @(negedge clk);
    chk("zero valid", {319'd0, dout_valid}, 320'd1);
    chk("zero dout", dout, 320'd0);
    step();

    // Random handshake, incrementing words
    nxt = 1;
    for (int i = 0; i < 10000; i++) begin
      din_valid  = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      din = mk5(nxt);
      @(negedge clk);
      r = din_ready;
      step();
      if (din_valid && r) nxt += 5;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
